// File: rtl/fx68k_regs_mp.sv
// Dual-port fx68k register file: a high lane plus two byte lanes, each with its own write enable.
// A clear sequencer fills every entry with INIT_VAL after reset; port accesses are ignored until it finishes.
module fx68k_regs_mp #(
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       HI_W     = 16,
  parameter int unsigned       DATA_W   = HI_W + 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit                PRIO_B   = 1'b1,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_ena,
  input  logic [ADDR_W-1:0] address_a,
  input  logic              wren_a,
  input  logic [2:0]        byteena_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic              wren_b,
  input  logic [2:0]        byteena_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;

  logic [HI_W-1:0] mem_hi [DEPTH];
  logic [7:0]      mem_b1 [DEPTH];
  logic [7:0]      mem_b0 [DEPTH];

  logic              same;
  logic [2:0]        wr_a, wr_b, coll, we_a, we_b, byp_a, byp_b;
  logic [DATA_W-1:0] old_a, old_b, win, nq_a, nq_b;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [2:0] en);
    return {{HI_W{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction

  // Per-lane write arbitration and next read data for both ports.
  always_comb begin
    same  = (address_a == address_b);
    wr_a  = {3{wren_a}} & byteena_a;
    wr_b  = {3{wren_b}} & byteena_b;
    coll  = wr_a & wr_b & {3{same}};
    we_a  = wr_a & ~(coll & {3{PRIO_B}});
    we_b  = wr_b & ~(coll & {3{~PRIO_B}});
    byp_a = ~wr_a & wr_b & {3{same & BYPASS}};
    byp_b = ~wr_b & wr_a & {3{same & BYPASS}};
    win   = PRIO_B ? data_b : data_a;
    old_a = {mem_hi[address_a], mem_b1[address_a], mem_b0[address_a]};
    old_b = {mem_hi[address_b], mem_b1[address_b], mem_b0[address_b]};
    nq_a  = (old_a  & ~lane_mask(wr_a | byp_a))
          | (data_a &  lane_mask(wr_a & ~coll))
          | (win    &  lane_mask(coll))
          | (data_b &  lane_mask(byp_a));
    nq_b  = (old_b  & ~lane_mask(wr_b | byp_b))
          | (data_b &  lane_mask(wr_b & ~coll))
          | (win    &  lane_mask(coll))
          | (data_a &  lane_mask(byp_b));
  end

  // Storage has no reset; a reset edge suppresses any write on that edge.
  always_ff @(posedge clk) begin
    if (rst_n && clk_ena) begin
      if (state == CLEAR) begin
        mem_hi[clr_addr] <= INIT_VAL[DATA_W-1:16];
        mem_b1[clr_addr] <= INIT_VAL[15:8];
        mem_b0[clr_addr] <= INIT_VAL[7:0];
      end else begin
        if (we_a[2]) mem_hi[address_a] <= data_a[DATA_W-1:16];
        if (we_a[1]) mem_b1[address_a] <= data_a[15:8];
        if (we_a[0]) mem_b0[address_a] <= data_a[7:0];
        if (we_b[2]) mem_hi[address_b] <= data_b[DATA_W-1:16];
        if (we_b[1]) mem_b1[address_b] <= data_b[15:8];
        if (we_b[0]) mem_b0[address_b] <= data_b[7:0];
      end
    end
  end

  // Clear sequencer and registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      q_a      <= '0;
      q_b      <= '0;
    end else if (clk_ena) begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          q_a <= nq_a;
          q_b <= nq_b;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
